spi_pattern_gen: RTL and testbench

Parametrised SPI-slave test-pattern source for the LA104 FPGA application slot. After a command byte from the host it streams an endless sequence of WIDTH-bit values on MISO, with optional high-impedance marker bits between values. Four generator modes are available: up-count, down-count, Gray and LFSR. Unlike the earlier fixed 4-bit counter, it shifts on real SCK edges rather than on every clk, and is runtime-configurable over MOSI.

---
 rtl/spi_pattern_gen.sv | 264 ++++++++++++++++++++++++++
 tb/tb_spi_pattern_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pattern_gen.sv
// spi_pattern_gen: SPI-slave (mode 0) test-pattern source.
// Streams up/down/Gray/LFSR values on MISO after a command byte.
//
// Ports:
//   clk   system clock, every flop lives here
//   rst   synchronous active-high reset
//   SSEL  slave select, active low, asynchronous pin
//   MOSI  host data, MSB first, sampled on SCK rise
//   SCK   SPI clock, asynchronous pin, idles low
//   MISO  driven only while presenting value bits
module spi_pattern_gen #(
  parameter int               WIDTH       = 8,
  parameter int               GAP_BITS    = 1,
  parameter int               LSB_FIRST   = 1,
  parameter logic [WIDTH-1:0] LFSR_TAPS   = 8'hB8,
  parameter int               SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic SSEL,
  input  logic MOSI,
  input  logic SCK,
  inout  wire  MISO
);

  localparam int CW = 5;
  localparam int GW = 4;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    GAP
  } state_t;

  logic [SYNC_STAGES-1:0] ssel_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   ssel_prev;
  logic                   sck_prev;

  logic ssel_s;
  logic sck_s;
  logic mosi_s;
  logic ssel_fall;
  logic sck_rise;
  logic sck_fall;

  state_t           state_q;
  state_t           state_n;
  logic [2:0]       cmd_q;
  logic [2:0]       cmd_n;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_n;
  logic [GW-1:0]    gcnt_q;
  logic [GW-1:0]    gcnt_n;
  logic [1:0]       mode_q;
  logic [1:0]       mode_n;
  logic             gap_en_q;
  logic             gap_en_n;
  logic [WIDTH-1:0] val_q;
  logic [WIDTH-1:0] val_n;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_n;
  logic             oe_q;
  logic             oe_n;
  logic             dout_q;
  logic             dout_n;

  logic [WIDTH-1:0] gen_val;
  logic [WIDTH-1:0] gen_bin;
  logic [WIDTH-1:0] bin_inc;
  logic [WIDTH-1:0] lfsr_nxt;
  logic [CW-1:0]    ord_idx;
  logic             cur_bit;

  // Synchronisers reset low so a held-low SSEL
  // after reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ssel_sync <= '0;
      sck_sync  <= '0;
      mosi_sync <= '0;
      ssel_prev <= 1'b0;
      sck_prev  <= 1'b0;
    end else begin
      ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], SSEL};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ssel_prev <= ssel_sync[SYNC_STAGES-1];
      sck_prev  <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign ssel_s    = ssel_sync[SYNC_STAGES-1];
  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ssel_fall = !ssel_s && ssel_prev;
  assign sck_rise  = sck_s && !sck_prev;
  assign sck_fall  = !sck_s && sck_prev;

  // Next generator value.
  always_comb begin
    bin_inc  = bin_q + WIDTH'(1);
    lfsr_nxt = (val_q >> 1)
             ^ (val_q[0] ? LFSR_TAPS : '0);
    gen_bin  = bin_q;
    gen_val  = val_q;
    unique case (mode_q)
      2'b00: gen_val = val_q + WIDTH'(1);
      2'b01: gen_val = val_q - WIDTH'(1);
      2'b10: begin
        gen_bin = bin_inc;
        gen_val = bin_inc ^ (bin_inc >> 1);
      end
      default: begin
        // A zero state would lock up; reseed.
        if (lfsr_nxt == '0) begin
          gen_val = WIDTH'(1);
        end else begin
          gen_val = lfsr_nxt;
        end
      end
    endcase
  end

  // Bit of the current value at the wire position
  // given by the bit counter and the shift order.
  always_comb begin
    if (LSB_FIRST != 0) begin
      ord_idx = cnt_q;
    end else begin
      ord_idx = CW'(WIDTH-1) - cnt_q;
    end
    cur_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ord_idx == CW'(i)) begin
        cur_bit = val_q[i];
      end
    end
  end

  always_comb begin
    state_n  = state_q;
    cmd_n    = cmd_q;
    cnt_n    = cnt_q;
    gcnt_n   = gcnt_q;
    mode_n   = mode_q;
    gap_en_n = gap_en_q;
    val_n    = val_q;
    bin_n    = bin_q;
    oe_n     = oe_q;
    dout_n   = dout_q;

    // Deselect beats any coincident SCK edge.
    if (ssel_s) begin
      state_n = IDLE;
      oe_n    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ssel_fall) begin
            state_n = CMD;
            cmd_n   = '0;
            cnt_n   = '0;
            gcnt_n  = '0;
            val_n   = '0;
            bin_n   = '0;
            oe_n    = 1'b0;
          end
        end

        CMD: begin
          if (sck_rise) begin
            // Only the low three command bits
            // matter; the rest shift through.
            cmd_n = {cmd_q[1:0], mosi_s};
            if (cnt_q == CW'(7)) begin
              mode_n   = cmd_n[1:0];
              gap_en_n = cmd_n[2];
              bin_n    = '0;
              cnt_n    = '0;
              gcnt_n   = '0;
              state_n  = DATA;
              if (cmd_n[1:0] == 2'b11) begin
                val_n = WIDTH'(1);
              end else begin
                val_n = '0;
              end
            end else begin
              cnt_n = cnt_q + CW'(1);
            end
          end
        end

        DATA: begin
          if (sck_fall) begin
            oe_n   = 1'b1;
            dout_n = cur_bit;
          end else if (sck_rise) begin
            if (cnt_q == CW'(WIDTH-1)) begin
              val_n  = gen_val;
              bin_n  = gen_bin;
              cnt_n  = '0;
              gcnt_n = '0;
              if (gap_en_q) begin
                state_n = GAP;
              end
            end else begin
              cnt_n = cnt_q + CW'(1);
            end
          end
        end

        GAP: begin
          if (sck_fall) begin
            if (gcnt_q == GW'(GAP_BITS)) begin
              state_n = DATA;
              oe_n    = 1'b1;
              dout_n  = cur_bit;
            end else begin
              oe_n   = 1'b0;
              gcnt_n = gcnt_q + GW'(1);
            end
          end
        end

        default: begin
          state_n = IDLE;
          oe_n    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      cnt_q    <= '0;
      gcnt_q   <= '0;
      mode_q   <= '0;
      gap_en_q <= 1'b0;
      val_q    <= '0;
      bin_q    <= '0;
      oe_q     <= 1'b0;
      dout_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      cmd_q    <= cmd_n;
      cnt_q    <= cnt_n;
      gcnt_q   <= gcnt_n;
      mode_q   <= mode_n;
      gap_en_q <= gap_en_n;
      val_q    <= val_n;
      bin_q    <= bin_n;
      oe_q     <= oe_n;
      dout_q   <= dout_n;
    end
  end

  assign MISO = oe_q ? dout_q : 1'bz;

endmodule

// File: tb/tb_spi_pattern_gen.sv
// tb_spi_pattern_gen: host-side bench for spi_pattern_gen.
// Scoreboard queue filled by stimulus, drained by a wire monitor.
module tb_spi_pattern_gen;

  localparam int HALF = 5;

  localparam logic [3:0] GRAY_TAB [20] = '{
    4'h0, 4'h1, 4'h3, 4'h2, 4'h6,
    4'h7, 4'h5, 4'h4, 4'hC, 4'hD,
    4'hF, 4'hE, 4'hA, 4'hB, 4'h9,
    4'h8, 4'h0, 4'h1, 4'h3, 4'h2
  };

  typedef struct {
    logic [31:0] val;
    bit          ne;
  } exp_t;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic ssel = 1'b1;
  logic sck  = 1'b0;
  logic mosi = 1'b0;
  wire  miso0;
  wire  miso1;
  wire  miso2;

  int nchk  = 0;
  int npass = 0;

  exp_t q[$];
  exp_t e;

  int   sel   = 0;
  int   w     = 8;
  bit   lsb   = 1;
  bit   gap   = 0;
  bit   gray  = 0;
  int   gbits = 1;
  bit   armed = 0;
  bit   zmode = 0;

  int          rcnt = 0;
  int          p    = 0;
  int          g    = 0;
  logic [31:0] acc  = '0;
  logic [31:0] prv  = '0;
  bit          have_prev = 0;
  bit          isz;
  logic        mv;

  always #5 clk = ~clk;

  spi_pattern_gen u0 (
    .clk(clk), .rst(rst), .SSEL(ssel),
    .MOSI(mosi), .SCK(sck), .MISO(miso0)
  );

  spi_pattern_gen #(
    .WIDTH(4), .GAP_BITS(1), .LFSR_TAPS(4'hC)
  ) u1 (
    .clk(clk), .rst(rst), .SSEL(ssel),
    .MOSI(mosi), .SCK(sck), .MISO(miso1)
  );

  spi_pattern_gen #(
    .WIDTH(8), .LSB_FIRST(0)
  ) u2 (
    .clk(clk), .rst(rst), .SSEL(ssel),
    .MOSI(mosi), .SCK(sck), .MISO(miso2)
  );

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    nchk++;
    if (ok) npass++;
    else $display("FAIL %s: got %0h, required %0h",
                  nm, act, req);
  endtask

  task automatic push(input logic [31:0] v,
                      input bit ne = 0);
    exp_t x;
    x.val = v;
    x.ne  = ne;
    q.push_back(x);
  endtask

  task automatic cfg(input int s, input int wd,
                     input bit l, input bit gp,
                     input bit gr, input int gb);
    sel   = s;
    w     = wd;
    lsb   = l;
    gap   = gp;
    gray  = gr;
    gbits = gb;
    zmode = 0;
    armed = 1;
  endtask

  task automatic sck_cycle(input logic m);
    mosi = m;
    repeat (HALF) @(negedge clk);
    sck = 1'b1;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] cmd);
    ssel = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 7; i >= 0; i--) sck_cycle(cmd[i]);
  endtask

  task automatic end_frame();
    repeat (HALF) @(negedge clk);
    ssel = 1'b1;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic drain(input string nm);
    chk(q.size() == 0, nm, q.size(), 0);
    q.delete();
  endtask

  // Monitor: SCK only moves with SSEL low and SSEL
  // only moves with SCK low, so the level tells
  // which edge woke us.
  always begin : monitor
    @(posedge sck or negedge ssel);
    if (!sck) begin
      rcnt = 0;
      p    = 0;
      g    = 0;
      acc  = '0;
      have_prev = 0;
    end else if (armed) begin
      isz = (sel == 0) ? (miso0 === 1'bz) :
            (sel == 1) ? (miso1 === 1'bz) :
                         (miso2 === 1'bz);
      mv  = (sel == 0) ? miso0 :
            (sel == 1) ? miso1 : miso2;
      if (zmode) begin
        chk(isz, "hiz_after_rst", {31'd0, isz}, 1);
      end else if (rcnt < 8) begin
        chk(isz, "cmd_hiz", {31'd0, isz}, 1);
        rcnt++;
      end else if (g > 0) begin
        chk(isz, "gap_hiz", {31'd0, isz}, 1);
        g--;
      end else begin
        chk(!isz, "data_driven", {31'd0, isz}, 0);
        if (lsb) acc[p] = mv;
        else acc[w-1-p] = mv;
        p++;
        if (p == w) begin
          if (q.size() == 0) begin
            chk(0, "unexpected_value", acc, 0);
          end else begin
            e = q.pop_front();
            if (e.ne) chk(acc != e.val, "value_ne",
                          acc, e.val);
            else chk(acc == e.val, "value",
                     acc, e.val);
          end
          if (gray && have_prev)
            chk($countones(acc ^ prv) == 1,
                "gray_1bit", acc ^ prv, 1);
          prv = acc;
          have_prev = 1;
          acc = '0;
          p = 0;
          if (gap) g = gbits;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk(miso0 === 1'bz, "rst_hiz0", 0, 1);
    chk(miso1 === 1'bz, "rst_hiz1", 0, 1);
    chk(miso2 === 1'bz, "rst_hiz2", 0, 1);

    // Up count, no gap.
    cfg(0, 8, 1, 0, 0, 1);
    push(8'h00); push(8'h01);
    push(8'h02); push(8'h03);
    start_frame(8'h00);
    repeat (32) sck_cycle(1'b0);
    end_frame();
    drain("up_drain");

    // Down count with gap, 4-bit.
    cfg(1, 4, 1, 1, 0, 1);
    push(4'h0); push(4'hF); push(4'hE);
    start_frame(8'h05);
    repeat (15) sck_cycle(1'b0);
    end_frame();
    drain("down_drain");

    // Gray, 4-bit, through the wrap.
    cfg(1, 4, 1, 0, 1, 1);
    for (int i = 0; i < 20; i++) push(GRAY_TAB[i]);
    start_frame(8'h02);
    repeat (80) sck_cycle(1'b0);
    end_frame();
    drain("gray_drain");

    // LFSR: seed repeats exactly at value 255.
    cfg(0, 8, 1, 0, 0, 1);
    push(8'h01); push(8'hB8);
    push(8'h5C); push(8'h2E);
    for (int i = 4; i < 255; i++) push(8'h01, 1);
    push(8'h01);
    start_frame(8'h03);
    repeat (256*8) sck_cycle(1'b0);
    end_frame();
    drain("lfsr_drain");

    // Abort 3 bits into the 2nd value.
    cfg(0, 8, 1, 0, 0, 1);
    push(8'h01);
    start_frame(8'h03);
    repeat (11) sck_cycle(1'b0);
    end_frame();
    drain("abort_drain");
    push(8'h01); push(8'hB8);
    start_frame(8'h03);
    repeat (16) sck_cycle(1'b0);
    end_frame();
    drain("restart_drain");

    // Reset mid-DATA with SSEL held low.
    cfg(0, 8, 1, 0, 0, 1);
    push(8'h00);
    start_frame(8'h00);
    repeat (12) sck_cycle(1'b0);
    repeat (HALF-1) @(negedge clk);
    chk(miso0 !== 1'bz, "driven_before_rst", 1, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk(miso0 === 1'bz, "hiz_1clk_rst", 0, 1);
    @(negedge clk);
    rst = 1'b0;
    zmode = 1;
    repeat (10) sck_cycle(1'b1);
    end_frame();
    drain("rst_drain");
    cfg(0, 8, 1, 0, 0, 1);
    push(8'h00); push(8'h01);
    start_frame(8'h00);
    repeat (16) sck_cycle(1'b0);
    end_frame();
    drain("post_rst_drain");

    // MSB first up to 0x81.
    cfg(2, 8, 0, 0, 0, 1);
    for (int i = 0; i < 130; i++) push(i);
    start_frame(8'h00);
    repeat (130*8) sck_cycle(1'b0);
    end_frame();
    drain("msb_drain");

    armed = 0;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
